// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with a single-word memory port
module dcache_wt #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] dcache_addr,
   input  logic [31:0] dcache_wdata,
   input  logic        dcache_req,
   input  logic        dcache_wr,
   output logic [31:0] dcache_rdata,
   output logic        dcache_rdy,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_req,
   output logic        mem_wr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdy
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TW = 28 - INDEX_BITS;
   typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;
   state_t state, state_n;
   logic [31:0] line_data [LINES][4];
   logic [TW-1:0] line_tag [LINES];
   logic [LINES-1:0] line_valid;
   logic [31:2] req_addr, req_addr_n;
   logic [1:0] cnt, cnt_n;
   logic [31:0] rdata_n, mem_addr_n, mem_wdata_n;
   logic rdy_n, mem_req_n, mem_wr_n;
   logic [INDEX_BITS-1:0] in_idx, r_idx;
   logic [TW-1:0] in_tag, r_tag;
   logic [1:0] in_off, r_off;
   logic hit, wr_hit, fill, fill_last, unused;

   assign in_idx    = dcache_addr[3+INDEX_BITS:4];
   assign in_tag    = dcache_addr[31:4+INDEX_BITS];
   assign in_off    = dcache_addr[3:2];
   assign r_idx     = req_addr[3+INDEX_BITS:4];
   assign r_tag     = req_addr[31:4+INDEX_BITS];
   assign r_off     = req_addr[3:2];
   assign hit       = line_valid[in_idx] && line_tag[in_idx] == in_tag;
   assign wr_hit    = state == IDLE && dcache_req && dcache_wr && hit;
   assign fill      = state == REFILL && mem_req && mem_rdy;
   assign fill_last = fill && cnt == 2'd3;
   assign unused    = ^dcache_addr[1:0];

   // line storage: store hits update in place, refills write one word per memory completion
   always_ff @(posedge clock) begin
      if (wr_hit) line_data[in_idx][in_off] <= dcache_wdata;
      if (fill) line_data[r_idx][cnt] <= mem_rdata;
      if (fill_last) line_tag[r_idx] <= r_tag;
   end

   // valid bits: cleared by reset, set only once a full line has arrived
   always_ff @(posedge clock) begin
      if (!reset) line_valid <= '0;
      else if (fill_last) line_valid[r_idx] <= 1'b1;
   end

   // state and registered outputs
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         req_addr     <= '0;
         dcache_rdy   <= 1'b0;
         dcache_rdata <= 32'h0;
         mem_req      <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= 32'h0;
         mem_wdata    <= 32'h0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         req_addr     <= req_addr_n;
         dcache_rdy   <= rdy_n;
         dcache_rdata <= rdata_n;
         mem_req      <= mem_req_n;
         mem_wr       <= mem_wr_n;
         mem_addr     <= mem_addr_n;
         mem_wdata    <= mem_wdata_n;
      end
   end

   // next state and next output values; the refill gap cycle is the REFILL cycle with mem_req low
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      req_addr_n  = req_addr;
      rdy_n       = 1'b0;
      rdata_n     = dcache_rdata;
      mem_req_n   = mem_req;
      mem_wr_n    = mem_wr;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      case (state)
         IDLE: if (dcache_req) begin
            req_addr_n = dcache_addr[31:2];
            if (dcache_wr) begin
               state_n     = WRITE;
               mem_req_n   = 1'b1;
               mem_wr_n    = 1'b1;
               mem_addr_n  = {dcache_addr[31:2], 2'b00};
               mem_wdata_n = dcache_wdata;
            end else if (hit) begin
               state_n = RESP;
               rdy_n   = 1'b1;
               rdata_n = line_data[in_idx][in_off];
            end else begin
               state_n    = REFILL;
               cnt_n      = 2'd0;
               mem_req_n  = 1'b1;
               mem_wr_n   = 1'b0;
               mem_addr_n = {dcache_addr[31:4], 4'b0000};
            end
         end
         REFILL: if (fill) begin
            mem_req_n = 1'b0;
            cnt_n     = cnt + 2'd1;
            if (fill_last) begin
               state_n = RESP;
               rdy_n   = 1'b1;
               rdata_n = r_off == 2'd3 ? mem_rdata : line_data[r_idx][r_off];
            end
         end else if (!mem_req) begin
            mem_req_n  = 1'b1;
            mem_addr_n = {req_addr[31:4], cnt, 2'b00};
         end
         WRITE: if (mem_rdy) begin
            state_n   = RESP;
            mem_req_n = 1'b0;
            mem_wr_n  = 1'b0;
            rdy_n     = 1'b1;
            rdata_n   = 32'h0;
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: scoreboard bench for dcache_wt with a wait-state memory model
module tb_dcache_wt;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] dcache_addr = 32'h0, dcache_wdata = 32'h0;
   logic        dcache_req = 1'b0, dcache_wr = 1'b0;
   logic [31:0] dcache_rdata;
   logic        dcache_rdy;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_req, mem_wr;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_rdy = 1'b0;

   int errors = 0, checks = 0;
   int wait_states = 2, w = 0, n_mem = 0;
   logic [31:0] cpu_q [$];
   logic [64:0] mem_q [$];
   logic [31:0] mem [logic [31:0]];
   logic prev_rdy = 1'b0;

   dcache_wt #(.INDEX_BITS(4)) dut (
      .clock(clock), .reset(reset),
      .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata), .dcache_req(dcache_req), .dcache_wr(dcache_wr),
      .dcache_rdata(dcache_rdata), .dcache_rdy(dcache_rdy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
   );

   always #5 clock = ~clock;

   task automatic check(input bit ok, input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory model: answers after wait_states cycles, compares each transaction with the scoreboard
   initial forever begin
      @(negedge clock);
      if (!reset) begin
         mem_rdy = 1'b0;
         w = 0;
      end else if (mem_rdy) begin
         check(mem_req == 1'b0, "mem_req_gap", 65'(mem_req), 65'h0);
         mem_rdy = 1'b0;
         w = 0;
      end else if (mem_req) begin
         if (w < wait_states) w++;
         else begin
            logic [64:0] got, exp;
            got = {mem_wr, mem_addr, mem_wr ? mem_wdata : 32'h0};
            exp = mem_q.size() > 0 ? mem_q.pop_front() : 'x;
            check(got === exp, "mem_txn", got, exp);
            if (mem_wr) mem[mem_addr] = mem_wdata;
            else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            mem_rdy = 1'b1;
            n_mem++;
            w = 0;
         end
      end
   end

   // CPU-side monitor: every completion pulse pops one expected load/store result
   initial forever begin
      @(negedge clock);
      if (dcache_rdy) begin
         logic [31:0] exp;
         exp = cpu_q.size() > 0 ? cpu_q.pop_front() : 'x;
         check(dcache_rdata === exp, "cpu_rdata", 65'(dcache_rdata), 65'(exp));
         check(!prev_rdy, "rdy_pulse", 65'(prev_rdy), 65'h0);
      end
      prev_rdy = dcache_rdy;
   end

   task automatic exp_refill(input logic [31:0] base);
      for (int i = 0; i < 4; i++) mem_q.push_back({1'b0, base + 32'(i * 4), 32'h0});
   endtask

   task automatic cpu(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input int exp_lat);
      int lat;
      cpu_q.push_back(exp_rdata);
      @(negedge clock);
      dcache_req = 1'b1; dcache_wr = wr; dcache_addr = a; dcache_wdata = wd;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!dcache_rdy && lat < 300);
      check(dcache_rdy, "cpu_timeout", 65'(dcache_rdy), 65'h1);
      if (exp_lat > 0) check(lat == exp_lat, "hit_latency", 65'(lat), 65'(exp_lat));
      dcache_req = 1'b0;
   endtask

   initial begin
      int t, n0;
      for (int i = 0; i < 4; i++) begin
         mem[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
         mem[32'h200 + 32'(i * 4)] = 32'hB0 + 32'(i);
         mem[32'h300 + 32'(i * 4)] = 32'hC0 + 32'(i);
      end
      repeat (3) @(negedge clock);
      check(dcache_rdy == 1'b0, "rst_rdy", 65'(dcache_rdy), 65'h0);
      check(dcache_rdata == 32'h0, "rst_rdata", 65'(dcache_rdata), 65'h0);
      check(mem_req == 1'b0, "rst_mem_req", 65'(mem_req), 65'h0);
      check(mem_wr == 1'b0, "rst_mem_wr", 65'(mem_wr), 65'h0);
      check(mem_addr == 32'h0, "rst_mem_addr", 65'(mem_addr), 65'h0);
      check(mem_wdata == 32'h0, "rst_mem_wdata", 65'(mem_wdata), 65'h0);
      reset = 1'b1;

      exp_refill(32'h100);
      cpu(1'b0, 32'h100, 32'h0, 32'hA0, 0);
      cpu(1'b0, 32'h108, 32'h0, 32'hA2, 1);
      mem_q.push_back({1'b1, 32'h104, 32'hDEADBEEF});
      cpu(1'b1, 32'h104, 32'hDEADBEEF, 32'h0, 0);
      cpu(1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 1);
      mem_q.push_back({1'b1, 32'h200, 32'h12345678});
      cpu(1'b1, 32'h200, 32'h12345678, 32'h0, 0);
      cpu(1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 1);
      wait_states = 0;
      exp_refill(32'h200);
      cpu(1'b0, 32'h200, 32'h0, 32'h12345678, 0);
      cpu(1'b0, 32'h204, 32'h0, 32'hB1, 1);
      wait_states = 1;
      exp_refill(32'h300);
      cpu(1'b0, 32'h30C, 32'h0, 32'hC3, 0);
      wait_states = 2;
      exp_refill(32'h100);
      cpu(1'b0, 32'h100, 32'h0, 32'hA0, 0);
      cpu(1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 1);

      mem_q.push_back({1'b0, 32'h300, 32'h0});
      mem_q.push_back({1'b0, 32'h304, 32'h0});
      n0 = n_mem;
      @(negedge clock);
      dcache_req = 1'b1; dcache_wr = 1'b0; dcache_addr = 32'h300;
      t = 0;
      do begin
         @(negedge clock);
         t++;
      end while (!(n_mem == n0 + 2 && mem_req && !mem_rdy) && t < 300);
      check(t < 300, "third_word_timeout", 65'(t), 65'h0);
      reset = 1'b0;
      dcache_req = 1'b0;
      @(negedge clock);
      check(mem_req == 1'b0, "midrefill_rst_mem_req", 65'(mem_req), 65'h0);
      check(dcache_rdy == 1'b0, "midrefill_rst_rdy", 65'(dcache_rdy), 65'h0);
      @(negedge clock);
      reset = 1'b1;
      exp_refill(32'h100);
      cpu(1'b0, 32'h100, 32'h0, 32'hA0, 0);
      cpu(1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 1);

      repeat (6) @(negedge clock);
      check(cpu_q.size() == 0, "cpu_q_drained", 65'(cpu_q.size()), 65'h0);
      check(mem_q.size() == 0, "mem_q_drained", 65'(mem_q.size()), 65'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- It is the responder for the CPU data port: it answers dcache_req/dcache_rdy on the CPU side.
- It is also the initiator of single-word transactions on a backing memory port that uses the same req/rdy handshake.
- It sits between the cpu top level and main memory.

Parameters:
INDEX_BITS, 4, log2 of line count (default 16 lines of 4 words = 256 bytes).

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
dcache_addr  in  32  byte address from CPU; bits [1:0] ignored
dcache_wdata  in  32  store data
dcache_req  in  1  request valid, held with addr/wr/wdata until dcache_rdy
dcache_wr  in  1  1 = store, 0 = load
dcache_rdata  out  32  load data, valid in the dcache_rdy cycle
dcache_rdy  out  1  one-cycle completion pulse
mem_addr  out  32  word-aligned memory address
mem_wdata  out  32  memory write data
mem_req  out  1  memory request, held until mem_rdy
mem_wr  out  1  1 = memory write
mem_rdata  in  32  memory read data, valid when mem_rdy
mem_rdy  in  1  memory completion pulse

Behaviour:
- Reset (reset==0 at a clock edge, any state):
  - all valid bits cleared; state -> IDLE; refill counter -> 0.
  - dcache_rdy=0, dcache_rdata=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - Any in-flight memory transaction is abandoned; the memory must tolerate mem_req dropping.
- Address split: offset=addr[3:2], index=addr[3+INDEX_BITS:4], tag=addr[31:4+INDEX_BITS].
- All outputs are registered.
- Handshake, both ports:
  - The requester holds req and its fields stable until rdy is high.
  - rdy is high for exactly one cycle.
  - The responder never samples a request in its own rdy cycle, so the earliest new request is sampled one edge after the rdy cycle.
  - The cache deasserts mem_req in the cycle after each mem_rdy.
- IDLE: request fields are latched at the edge where dcache_req==1.
  - Read hit -> RESP: dcache_rdy=1 and dcache_rdata=line word in the next cycle. Latency is 1 cycle after sampling.
  - Read miss -> REFILL with cnt=0. Drive mem_req=1, mem_wr=0, mem_addr={tag,index,cnt,2'b00}.
  - Write (hit or miss) -> WRITE. Drive mem_req=1, mem_wr=1, mem_addr={addr[31:2],2'b00}, mem_wdata=dcache_wdata.
  - On a write hit, the cached word is updated at the sampling edge.
  - On a write miss, no allocation occurs and tag/valid are unchanged.
- REFILL:
  - At the edge with mem_rdy: store mem_rdata into word cnt, drop mem_req for one cycle, cnt++.
  - If cnt was not 3, re-raise mem_req with the next address after the gap cycle.
  - When cnt was 3: write tag, set valid, go to RESP. The requested word comes from the refilled line; a just-arrived word is forwarded.
- WRITE: at the edge with mem_rdy, drop mem_req and go to RESP. dcache_rdy=1 and dcache_rdata=0 for stores.
- RESP: one cycle with dcache_rdy=1, then IDLE.
- Refill word order: always offset 0..3, regardless of the requested offset.
- Memory wait states are arbitrary (0..N cycles). The cache holds mem_req/mem_addr stable for the whole wait.
- Only one outstanding CPU request. dcache_req changes outside IDLE are ignored.
- Line replacement on a read miss discards the old line (write-through means no dirty data).

Test Plan:
- Cold read of 0x100; memory returns 0xA0..0xA3 with 2 wait states each -> mem reads at 0x100, 0x104, 0x108, 0x10C in order, with mem_req low for one cycle between them; dcache_rdy once with dcache_rdata=0xA0.
- Read 0x108 after that refill -> dcache_rdy one cycle after sampling, rdata=0xA2, mem_req stays 0.
- Write 0x104 with 0xDEADBEEF (hit) -> one mem write to 0x104 with 0xDEADBEEF, dcache_rdy after mem_rdy. Then read 0x104 -> 0xDEADBEEF with no memory traffic.
- Write miss at 0x200 with 0x12345678 -> one mem write only. Read 0x104 still hits, since index 0 is not evicted. Read 0x200 -> 4-word refill from 0x200.
- Conflict: read 0x300 after 0x100 is cached -> refill from 0x300. A subsequent read of 0x100 misses and refills again.
- Assert reset=0 during the 3rd refill word (mem_req high) -> next cycle mem_req=0 and dcache_rdy=0. After release, read 0x100 misses and refills all 4 words.
